// File: rtl/codec_pkg.sv
// codec_pkg: shared defaults and types for the codec-side serial audio slave.
//   DATA_W_DEF      - default frame width in bits
//   SYNC_STAGES_DEF - default synchroniser depth for b_clk / lr_clk / dacdat
//   state_e         - link state: UNLOCKED until the first frame start, then LOCKED
package codec_pkg;
  localparam int DATA_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;
endpackage

// File: rtl/codec_edge_sync.sv
// codec_edge_sync: STAGES-deep synchroniser followed by one delay flop, giving
// the synchronised level plus single-cycle rise/fall pulses.
//   clk_i, reset_i - system clock, synchronous active-high reset
//   d_i            - asynchronous input
//   level_o        - synchronised level
//   rise_o/fall_o  - one-cycle pulses on a synchronised 0->1 / 1->0 transition
module codec_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  sync_q[STAGES-1] & ~dly_q;
  assign fall_o  = ~sync_q[STAGES-1] &  dly_q;
endmodule

// File: rtl/codec_serial_slave.sv
// codec_serial_slave: codec end of the serial audio link.
//   clk_i, reset_i      - system clock, synchronous active-high reset
//   b_clk_i, lr_clk_i   - bit clock and frame clock from the master
//   dacdat_i            - serial DAC data, MSB first
//   adcdat_o            - serial ADC data, MSB first
//   rx_data_o/rx_valid_o- last complete DAC word / one-cycle update pulse
//   tx_data_i/tx_valid_i/tx_ready_o - ADC word handshake into a one-entry holding register
//   locked_o            - a frame start has been seen since reset
//   underrun_o          - pulse: frame started with no ADC word available
//   frame_err_o         - pulse: previous frame was not DATA_W bits long
module codec_serial_slave
  import codec_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              b_clk_i,
  input  logic              lr_clk_i,
  input  logic              dacdat_i,
  output logic              adcdat_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              locked_o,
  output logic              underrun_o,
  output logic              frame_err_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_W + 1);

  // lane 0: b_clk, lane 1: lr_clk, lane 2: dacdat -- identical delay keeps data aligned to edges
  logic [2:0] lvl, rise, fall;

  codec_edge_sync #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     ({dacdat_i, lr_clk_i, b_clk_i}),
    .level_o (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  logic b_rise, b_fall, lr_rise, dac_bit;
  assign b_rise  = rise[0];
  assign b_fall  = fall[0];
  assign lr_rise = rise[1];
  assign dac_bit = lvl[2];

  logic unused_ok;
  assign unused_ok = &{1'b0, lvl[1:0], rise[2], fall[2:1]};

  // FSM
  state_e state_q, state_d;
  logic   is_locked;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= UNLOCKED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == UNLOCKED && lr_rise) state_d = LOCKED;
  end

  always_comb begin
    is_locked = (state_q == LOCKED);
  end

  // datapath
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              rx_valid_q, rx_valid_d, hold_full_q, hold_full_d;
  logic              underrun_q, underrun_d, frame_err_q, frame_err_d;
  logic              tx_xfer;

  assign tx_xfer = tx_valid_i & ~hold_full_q;

  always_comb begin
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    if (lr_rise) begin
      // frame start wins over a coincident b_fall: load, no shift
      frame_err_d = is_locked && (bit_cnt_q != CNT_FULL);
      bit_cnt_d   = '0;
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else if (tx_xfer) begin
        tx_shift_d  = tx_data_i;    // bypass: word arrived exactly at frame start
      end else begin
        tx_shift_d  = '0;
        underrun_d  = 1'b1;
      end
    end else begin
      if (tx_xfer) begin
        hold_d      = tx_data_i;
        hold_full_d = 1'b1;
      end
      if (is_locked && b_rise) begin
        rx_shift_d = {rx_shift_q[DATA_W-2:0], dac_bit};
        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_LAST) begin
          rx_data_d  = rx_shift_d;
          rx_valid_d = 1'b1;
        end
      end
      if (is_locked && b_fall) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  // tx_shift is only loaded by a frame start, so it is zero while UNLOCKED
  assign adcdat_o    = tx_shift_q[DATA_W-1];
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign tx_ready_o  = ~hold_full_q;
  assign locked_o    = is_locked;
  assign underrun_o  = underrun_q;
  assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_codec_serial_slave.sv
// Bench for codec_serial_slave: a bench-side serial master drives b_clk/lr_clk/dacdat
// and reads adcdat; expected DAC and ADC words go into queues checked by monitors.
module tb_codec_serial_slave;
  localparam int SS   = 2;
  localparam int HALF = 16;   // b_clk = clk/32

  logic        clk, reset, b_clk, lr_clk, dacdat, adcdat;
  logic [31:0] rx_data, tx_data;
  logic        rx_valid, tx_valid, tx_ready, locked, underrun, frame_err;

  codec_serial_slave #(.DATA_W(32), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .reset_i(reset), .b_clk_i(b_clk), .lr_clk_i(lr_clk),
    .dacdat_i(dacdat), .adcdat_o(adcdat), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .locked_o(locked), .underrun_o(underrun), .frame_err_o(frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int n_und = 0, n_ferr = 0, exp_und = 0, exp_ferr = 0;
  logic [31:0] rx_q[$];
  logic [31:0] adc_q[$];
  logic [31:0] adc_obs;
  bit          chk_rdy = 0;
  event        adc_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rx monitor and pulse counters
  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
      else chk("rx_data", rx_data, rx_q.pop_front());
    end
    if (underrun)  n_und++;
    if (frame_err) n_ferr++;
  end

  // adc monitor: word assembled by the master
  initial forever begin
    @(adc_ev);
    if (adc_q.size() == 0) chk("adc_unexpected", 32'd1, 32'd0);
    else chk("adc_word", adc_obs, adc_q.pop_front());
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [31:0] w);
    int t = 0;
    @(negedge clk); tx_valid = 1'b1; tx_data = w;
    while (!tx_ready && t < 200) begin @(negedge clk); t++; end
    chk("push_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk); tx_valid = 1'b0;
  endtask

  // One master frame of nbits; byp asserts tx_valid in the exact lr_rise cycle.
  task automatic frame(input logic [31:0] dac, input int nbits, input bit exp_rx,
                       input bit chk_adc, input logic [31:0] adc_exp,
                       input bit byp, input logic [31:0] byp_w);
    logic [31:0] sh = '0;
    if (exp_rx)  rx_q.push_back(dac);
    if (chk_adc) adc_q.push_back(adc_exp);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b_clk = 1'b0; lr_clk = (i == 0); dacdat = dac[31-i];
      if (i == 0 && byp) begin
        repeat (SS) @(posedge clk);
        @(negedge clk); tx_valid = 1'b1; tx_data = byp_w;
        @(posedge clk);
        @(negedge clk); tx_valid = 1'b0;
        repeat (HALF - SS - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i == 0 && chk_rdy) chk("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
      b_clk = 1'b1;
      sh = {sh[30:0], adcdat};
      repeat (HALF) @(negedge clk);
    end
    if (chk_adc) begin adc_obs = sh; -> adc_ev; end
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); b_clk = 1'b0; dacdat = 1'b1;
      repeat (HALF) @(negedge clk);
      b_clk = 1'b1;
      repeat (HALF - 1) @(negedge clk);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_underrun_cnt"}, n_und, exp_und);
    chk({tag, "_frame_err_cnt"}, n_ferr, exp_ferr);
  endtask

  initial begin
    reset = 1'b1; b_clk = 1'b0; lr_clk = 1'b0; dacdat = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_adcdat", {31'd0, adcdat}, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_pulses", {30'd0, underrun, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // basic loopback
    push(32'h1357_9BDF);
    frame(32'hA5A5_0F0F, 32, 1, 1, 32'h1357_9BDF, 0, '0);
    chk("locked_after_frame", {31'd0, locked}, 32'd1);

    // tx_ready drops on write, returns at frame start
    push(32'hDEAD_BEEF);
    @(negedge clk);
    chk("tx_ready_held", {31'd0, tx_ready}, 32'd0);
    chk_rdy = 1;
    frame(32'h1234_5678, 32, 1, 1, 32'hDEAD_BEEF, 0, '0);
    chk_rdy = 0;
    chk_counts("loopback");

    // underrun: no word supplied
    exp_und++;
    frame(32'h0F0F_A5A5, 32, 1, 1, 32'h0000_0000, 0, '0);
    chk_counts("underrun");

    // bypass in the lr_rise cycle
    frame(32'hFFFF_0000, 32, 1, 1, 32'h0000_FFFF, 1, 32'h0000_FFFF);
    chk_counts("bypass");
    chk("tx_ready_after_bypass", {31'd0, tx_ready}, 32'd1);

    // truncated frame then a good one
    push(32'h2468_ACE0);
    frame(32'hC3C3_C3C3, 31, 0, 0, '0, 0, '0);
    push(32'h7FFF_FFFE);
    exp_ferr++;
    frame(32'h8000_0001, 32, 1, 1, 32'h7FFF_FFFE, 0, '0);
    chk_counts("truncated");

    // reset mid-frame with a full holding register
    push(32'h55AA_55AA);
    frame(32'hFFFF_FFFF, 10, 0, 0, '0, 0, '0);
    push(32'h3333_3333);
    @(negedge clk);
    chk("hold_full_pre_reset", {31'd0, tx_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_adcdat", {31'd0, adcdat}, 32'd0);
    chk("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    idle_bits(22);
    chk("unlocked_adcdat", {31'd0, adcdat}, 32'd0);
    chk("unlocked_locked", {31'd0, locked}, 32'd0);
    push(32'h0BAD_CAFE);
    frame(32'h600D_F00D, 32, 1, 1, 32'h0BAD_CAFE, 0, '0);
    chk("relocked", {31'd0, locked}, 32'd1);
    chk_counts("after_reset");

    repeat (10) @(negedge clk);
    chk("rx_queue_drained", rx_q.size(), 32'd0);
    chk("adc_queue_drained", adc_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/codec_serial_slave.md
# codec_serial_slave

Codec-side end of the 32-bit serial audio link. Receives the master's bit clock (`b_clk`), frame clock (`lr_clk`) and DAC data (`dacdat`), and deserialises each DAC frame into a parallel word. Drives ADC data (`adcdat`) back, serialised from a parallel word supplied through a valid/ready handshake. Used as a codec model in loopback benches and as the slave port when an FPGA peer owns the clocks.

## Interface
- `DATA_W`, 32: frame width in bits (one frame = `DATA_W` `b_clk` periods).
- `SYNC_STAGES`, 2: synchroniser depth applied identically to `b_clk`, `lr_clk` and `dacdat`.
- `clk`  in  1  system clock; one clock domain, `b_clk` slower than `clk`/8.
- `reset`  in  1  synchronous, active-high reset.
- `b_clk`  in  1  bit clock from master.
- `lr_clk`  in  1  frame clock from master; a rising edge marks frame start.
- `dacdat`  in  1  serial DAC data, MSB first, changes on `b_clk` falling edge.
- `adcdat`  out  1  serial ADC data, MSB first, changes on `b_clk` falling edge.
- `rx_data`  out  `DATA_W`  last complete DAC word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `tx_data`  in  `DATA_W`  next ADC word.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  holding register is empty.
- `locked`  out  1  first frame start seen since reset.
- `underrun`  out  1  one-cycle pulse: frame started with no ADC word available.
- `frame_err`  out  1  one-cycle pulse: frame length was not `DATA_W` bits.

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one delay flop.
- Edge events: `b_rise`, `b_fall` and `lr_rise`, each a single-cycle pulse.
- `lr_rise` arrives in the same cycle as `b_fall`. In that case `lr_rise` takes priority: load, no shift.
- States:
  - UNLOCKED (after reset): ignore `b` edges. On `lr_rise`, go to LOCKED and set `locked`=1.
  - LOCKED: stays there until `reset`.
- RX path (LOCKED):
  - On each `b_rise`, shift synchronised `dacdat` into the LSB of `rx_shift` and increment `bit_cnt`. `bit_cnt` is `$clog2(DATA_W)+1` bits and saturates at `DATA_W`+1.
  - On the `b_rise` that brings `bit_cnt` to `DATA_W`: `rx_data` <= shifted word, `rx_valid`=1 for one cycle.
  - On `lr_rise`: if `bit_cnt` is not `DATA_W` and this is not the first `lr_rise`, pulse `frame_err`. Then clear `bit_cnt`.
- TX path:
  - One-entry holding register. `tx_ready` = ~`hold_full`. A transfer happens on `tx_valid & tx_ready`.
  - On `lr_rise`, load `tx_shift`:
    - from the holding register if it is full, and clear `hold_full`;
    - else, if a transfer occurs in that same cycle, load `tx_data` directly (bypass) and leave `hold_full`=0;
    - else load zeros and pulse `underrun`.
  - On `b_fall` without `lr_rise`: `tx_shift` <= {`tx_shift[DATA_W-2:0]`, 0}.
  - `adcdat` = `tx_shift[DATA_W-1]`, registered; it is 0 while UNLOCKED.
- Reset values:
  - `adcdat`, `rx_data`, `rx_valid`, `locked`, `underrun`, `frame_err` = 0.
  - `tx_ready`=1. FSM state = UNLOCKED.
- Reset mid-frame drops partial words and the holding register. Resync happens at the next `lr_rise`.

## Timing
- Input edge to internal event: `SYNC_STAGES`+1 `clk` cycles. Event to `adcdat` change: +1 cycle.
- Total `b_clk` falling edge to `adcdat` change is `SYNC_STAGES`+2 cycles, which must be less than half a `b_clk` period.
- The master samples `adcdat` on `b_rise`. After the 32nd rise, the master's 32-bit buffer equals the loaded word.
- `rx_valid` asserts `SYNC_STAGES`+2 cycles after the 32nd `b_clk` rising edge of the frame.
- The holding register must be written before `lr_rise`. Writing one per `rx_valid` meets this with about half a `b_clk` period of margin.

## Structure
- Package `codec_pkg`: `DATA_W` default, `SYNC_STAGES` default, and the FSM state enum {UNLOCKED, LOCKED}.
- Sub-module `codec_edge_sync`: an N-stage synchroniser plus a delay flop per input. Outputs the synchronised level, rise pulse and fall pulse.

## Test plan
- Loopback with the existing master (`clk` 50 MHz, `b_clk` = `clk`/32). Master sends 0xA5A5_0F0F, 0x1234_5678. `rx_data` shows each word with one `rx_valid` per frame. No `frame_err`.
- Push `tx_data`=0xDEAD_BEEF before the frame. The master's ADC word read at the next load tick is 0xDEAD_BEEF. `tx_ready` drops on the write and rises at `lr_rise`.
- No `tx_valid` for one frame: `underrun` pulses once, and the master reads 0x0000_0000.
- `tx_valid` asserted in the same cycle as `lr_rise` with the holding register empty: the bypass word 0x0000_FFFF is transmitted and `underrun` stays 0.
- Truncated frame (31 `b_clk` rises, then `lr_clk` rises): `frame_err` pulses once and there is no `rx_valid`. The next 32-bit frame 0x8000_0001 is received correctly.
- Assert `reset` for 1 cycle mid-frame: `locked`=0 and `adcdat`=0. No `rx_valid` until the first full frame after the next `lr_rise`.
